md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request from the pipeline execute stage to begin an operation.
REQ-004 SHALL have port md_op, input, 2 bits: operation select; 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-005 SHALL have ports src_a and src_b, input, 32 bits each: operands, sampled only when an operation is accepted.
REQ-006 SHALL have port hl_we, input, 1 bit: direct HI/LO write strobe for MTHI/MTLO.
REQ-007 SHALL have port hl_sel, input, 1 bit: direct-write target; 1=HI, 0=LO.
REQ-008 SHALL have port hl_wdata, input, 32 bits: direct-write data.
REQ-009 SHALL have port busy, output, 1 bit: operation in flight; the pipeline stalls HI/LO accesses on busy|start.
REQ-010 SHALL have ports hi and lo, output, 32 bits each: current register contents, driven straight from flops.

Function
REQ-011 SHALL use a two-state FSM: IDLE (busy=0) and RUN (busy=1), with a latency counter cnt.
REQ-012 In IDLE with start=1, SHALL capture operands and md_op, load cnt with the latency, and enter RUN on the same edge.
REQ-013 Latency SHALL be 5 cycles for MULT/MULTU and 10 cycles for DIV/DIVU; busy is high for exactly that many cycles, starting the cycle after start.
REQ-014 In RUN, cnt SHALL decrement each cycle; on the edge where cnt reaches 1, the result SHALL be written to HI/LO and the FSM SHALL return to IDLE.
REQ-015 MULT SHALL write the signed 64-bit product, MULTU the unsigned product; HI={prod[63:32]}, LO={prod[31:0]}.
REQ-016 DIV/DIVU SHALL write LO=quotient and HI=remainder; the signed form truncates toward zero and the remainder takes the sign of the dividend.
REQ-017 On divide by zero, HI and LO SHALL keep their values; busy timing SHALL be unchanged.
REQ-018 Signed 0x80000000 / -1 SHALL give LO=0x80000000 and HI=0.
REQ-019 start while busy SHALL be ignored; the operation in flight is unaffected.
REQ-020 With hl_we=1 in IDLE and start=0, the selected register SHALL be loaded with hl_wdata on the next edge.
REQ-021 hl_we while busy SHALL be ignored.
REQ-022 If hl_we=1 and start=1 in the same IDLE cycle, start SHALL win and hl_we SHALL be ignored.
REQ-023 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-024 While reset=1 at an edge, SHALL force state=IDLE, busy=0, cnt=0, hi=0 and lo=0.
REQ-025 reset SHALL abort an in-flight operation without writing its result; reset SHALL take priority over start and hl_we.

Configuration
REQ-026 Macro MD_UNIT_DIV_EN: when defined, DIV/DIVU SHALL be implemented per REQ-013/016/017/018.
REQ-027 When MD_UNIT_DIV_EN is undefined, start with md_op=2 or 3 SHALL be a no-op: busy stays 0 and HI/LO are unchanged; MULT/MULTU behave identically in both builds.

Structure
REQ-028 The shared package md_pkg SHALL hold the md_op encodings, the constants MUL_LAT=5 and DIV_LAT=10, and the FSM state encoding.
REQ-029 Result arithmetic SHALL sit in one combinational sub-module, md_calc (inputs: captured op and operands; outputs: hi_res, lo_res, div_zero); md_unit holds the FSM, counter and registers.

Verification
REQ-030 MULT with a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x00000001 and lo=0xFFFFFFFE.
REQ-031 DIV with a=-7, b=2 -> busy high 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU with a=7, b=0 -> hi/lo unchanged after 10 busy cycles.
REQ-032 MULT 3*4 followed by start of MULT 5*5 on busy cycle 2 -> second start ignored; lo=12; busy falls after exactly 5 cycles.
REQ-033 hl_we=1, hl_sel=1, hl_wdata=0x1234 while busy -> ignored; the same write in IDLE -> hi=0x1234 the next cycle; simultaneous start and hl_we -> only the multiply result lands.
REQ-034 reset asserted on busy cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, and no late write occurs.
REQ-035 Build without MD_UNIT_DIV_EN, start a DIVU -> busy stays 0 and HI/LO are unchanged; the MULT check from REQ-030 still passes.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// latencies and FSM state encoding.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;
  localparam int unsigned CNT_W   = 4;

  // Both divide encodings share the upper op bit.
  function automatic logic is_div(input md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result datapath for md_unit. Divide hardware exists only
// when MD_UNIT_DIV_EN is defined; otherwise the divide outputs are zero.
module md_calc
  import md_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic [63:0] mulA, mulB, prod;
  logic [31:0] quo, rem;

  always_comb begin
    mulA = (op == OP_MULT) ? {{32{a[31]}}, a} : {32'b0, a};
    mulB = (op == OP_MULT) ? {{32{b[31]}}, b} : {32'b0, b};
    prod = mulA * mulB;
  end

`ifdef MD_UNIT_DIV_EN
  logic        signA, signB;
  logic [31:0] magA, magB, divisor, q, r;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero
  // and the remainder follows the dividend. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 with no special case.
  always_comb begin
    signA   = (op == OP_DIV) && a[31];
    signB   = (op == OP_DIV) && b[31];
    magA    = signA ? (32'd0 - a) : a;
    magB    = signB ? (32'd0 - b) : b;
    divisor = (b == 32'd0) ? 32'd1 : magB;
    q       = magA / divisor;
    r       = magA % divisor;
    quo     = (signA ^ signB) ? (32'd0 - q) : q;
    rem     = signA ? (32'd0 - r) : r;
  end
`else
  always_comb begin
    quo = 32'd0;
    rem = 32'd0;
  end
`endif

  always_comb begin
    div_zero = (b == 32'd0);
    if (is_div(op)) begin
      hi_res = rem;
      lo_res = quo;
    end else begin
      hi_res = prod[63:32];
      lo_res = prod[31:0];
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a fixed-latency
// busy window. Define MD_UNIT_DIV_EN to enable DIV/DIVU.
module md_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hl_we,
  input  logic        hl_sel,
  input  logic [31:0] hl_wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hiRes, loRes;
  logic             divZero, opOk;
  md_op_e           opIn;

  assign opIn = md_op_e'(md_op);

`ifdef MD_UNIT_DIV_EN
  assign opOk = 1'b1;
`else
  assign opOk = !is_div(opIn);
`endif

  md_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_res   (hiRes),
    .lo_res   (loRes),
    .div_zero (divZero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        // A start always blocks a same-cycle direct write, even if rejected.
        if (start) begin
          if (opOk) begin
            op_d    = opIn;
            a_d     = src_a;
            b_d     = src_b;
            cnt_d   = is_div(opIn) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            state_d = S_RUN;
          end
        end else if (hl_we) begin
          if (hl_sel) hi_d = hl_wdata;
          else        lo_d = hl_wdata;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          if (!(is_div(op_q) && divZero)) begin
            hi_d = hiRes;
            lo_d = loRes;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus queues expected HI/LO and latency,
// a monitor checks them each time a busy window closes.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        hl_we = 1'b0;
  logic        hl_sel = 1'b0;
  logic [31:0] hl_wdata = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t expQ[$];

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hl_we    (hl_we),
    .hl_sel   (hl_sel),
    .hl_wdata (hl_wdata),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and scores each completed operation.
  initial begin : monitor
    int runLen;
    exp_t e;
    runLen = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        runLen++;
      end else if (runLen > 0) begin
        if (!reset) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected completion", 32'(runLen), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("latency", 32'(runLen), 32'(e.lat));
            checkOutput("hi", hi, e.hi);
            checkOutput("lo", lo, e.lo);
          end
        end
        runLen = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    src_a = 32'hA5A5_5A5A;
    src_b = 32'h0F0F_F0F0;
  endtask

  task automatic pushExp(input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.lat = lat;
    expQ.push_back(e);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (n >= 30) checkOutput("busy timeout", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic hlWrite(input logic sel, input logic [31:0] data, input logic withStart,
                         input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    hl_we = 1'b1;
    hl_sel = sel;
    hl_wdata = data;
    start = withStart;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk); #1;
    hl_we = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset = 1'b0;

    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'd2);
    waitIdle();
    pushExp(32'h0000_0001, 32'hFFFF_FFFE, 5);
    applyStimulus(2'd1, 32'hFFFF_FFFF, 32'd2);
    waitIdle();

    // Second start on busy cycle 2 must be ignored.
    pushExp(32'd0, 32'd12, 5);
    applyStimulus(2'd0, 32'd3, 32'd4);
    applyStimulus(2'd0, 32'd5, 32'd5);
    waitIdle();

    // Direct write during busy is dropped.
    pushExp(32'd0, 32'd6, 5);
    applyStimulus(2'd0, 32'd2, 32'd3);
    hlWrite(1'b1, 32'h1234, 1'b0, 2'd0, 32'd0, 32'd0);
    waitIdle();

    hlWrite(1'b1, 32'h1234, 1'b0, 2'd0, 32'd0, 32'd0);
    checkOutput("idle write hi", hi, 32'h1234);
    checkOutput("idle write lo kept", lo, 32'd6);

    // Start beats a same-cycle direct write.
    pushExp(32'd0, 32'd56, 5);
    hlWrite(1'b0, 32'hDEAD, 1'b1, 2'd1, 32'd7, 32'd8);
    waitIdle();

    hlWrite(1'b0, 32'hCAFE, 1'b0, 2'd0, 32'd0, 32'd0);
    checkOutput("idle write lo", lo, 32'hCAFE);
    checkOutput("idle write hi kept", hi, 32'd0);

`ifdef MD_UNIT_DIV_EN
    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2);
    waitIdle();
    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    applyStimulus(2'd3, 32'd7, 32'd0);
    waitIdle();
    pushExp(32'd0, 32'h8000_0000, 10);
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();
    pushExp(32'd1, 32'hFFFF_FFFD, 10);
    applyStimulus(2'd2, 32'd7, 32'hFFFF_FFFE);
    waitIdle();
    pushExp(32'd2, 32'd14, 10);
    applyStimulus(2'd3, 32'd100, 32'd7);
    waitIdle();
    applyStimulus(2'd2, 32'd100, 32'd7);
`else
    applyStimulus(2'd3, 32'd7, 32'd3);
    checkOutput("nodiv busy", {31'b0, busy}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("nodiv busy later", {31'b0, busy}, 32'd0);
    checkOutput("nodiv hi", hi, 32'd0);
    checkOutput("nodiv lo", lo, 32'hCAFE);
    applyStimulus(2'd0, 32'd100, 32'd7);
`endif

    // Abort on busy cycle 3.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort busy before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("no late write hi", hi, 32'd0);
    checkOutput("no late write lo", lo, 32'd0);
    checkOutput("no late busy", {31'b0, busy}, 32'd0);

    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'd2);
    waitIdle();

    repeat (2) @(posedge clk);
    checkOutput("pending expectations", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
